// File: rtl/elastic_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, optional 2-entry
// skid buffer (registered in_ready), synchronous flush and occupancy output.
module elastic_stage_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_read,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_result,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_read,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_result,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic              wb_en;
    logic              mem_read;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_result;
    logic [DEST_W-1:0] dest;
  } payload_t;

  state_t   state_q, state_d;
  payload_t main_q, skid_q, in_payload;
  logic     in_fire, out_fire;
  logic     load_main_in, load_main_skid, load_skid;

  assign in_payload = '{wb_en:      in_wb_en,
                        mem_read:   in_mem_read,
                        alu_result: in_alu_result,
                        mem_result: in_mem_result,
                        dest:       in_dest};

  assign out_valid = (state_q != EMPTY);
  // With the skid buffer, in_ready comes only from the state flops so the
  // downstream ready never reaches upstream combinationally.
  assign in_ready  = (SKID != 0) ? (state_q != SKID_FULL) : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = state_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = FULL;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire && (SKID != 0)) begin
          load_skid = 1'b1;
          state_d   = SKID_FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; the incoming beat is dropped and payload
    // registers keep their contents.
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: payload registers are reset as well so a reset mid-transfer leaves
  // no stale data visible on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_payload;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_payload;
    end
  end

  // Control bits are gated so a bubble can never write the register file.
  assign out_wb_en      = main_q.wb_en && out_valid;
  assign out_mem_read   = main_q.mem_read && out_valid;
  assign out_alu_result = main_q.alu_result;
  assign out_mem_result = main_q.mem_result;
  assign out_dest       = main_q.dest;

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Directed self-checking bench for elastic_stage_reg: one SKID=1 instance and
// one SKID=0 instance sharing clock and reset.
module tb_elastic_stage_reg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // SKID=1 instance signals
  logic              s_flush = 0, s_in_valid = 0, s_in_ready, s_in_wb_en = 0, s_in_mem_read = 0;
  logic [DATA_W-1:0] s_in_alu = '0, s_in_mem = '0;
  logic [DEST_W-1:0] s_in_dest = '0;
  logic              s_out_valid, s_out_ready = 0, s_out_wb_en, s_out_mem_read;
  logic [DATA_W-1:0] s_out_alu, s_out_mem;
  logic [DEST_W-1:0] s_out_dest;
  logic [1:0]        s_occ;

  // SKID=0 instance signals
  logic              n_flush = 0, n_in_valid = 0, n_in_ready, n_in_wb_en = 0, n_in_mem_read = 0;
  logic [DATA_W-1:0] n_in_alu = '0, n_in_mem = '0;
  logic [DEST_W-1:0] n_in_dest = '0;
  logic              n_out_valid, n_out_ready = 0, n_out_wb_en, n_out_mem_read;
  logic [DATA_W-1:0] n_out_alu, n_out_mem;
  logic [DEST_W-1:0] n_out_dest;
  logic [1:0]        n_occ;

  elastic_stage_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .SKID(1)) dut_skid (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_wb_en(s_in_wb_en), .in_mem_read(s_in_mem_read),
    .in_alu_result(s_in_alu), .in_mem_result(s_in_mem), .in_dest(s_in_dest),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_wb_en(s_out_wb_en), .out_mem_read(s_out_mem_read),
    .out_alu_result(s_out_alu), .out_mem_result(s_out_mem), .out_dest(s_out_dest),
    .occupancy(s_occ)
  );

  elastic_stage_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .SKID(0)) dut_noskid (
    .clk(clk), .rst(rst), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_wb_en(n_in_wb_en), .in_mem_read(n_in_mem_read),
    .in_alu_result(n_in_alu), .in_mem_result(n_in_mem), .in_dest(n_in_dest),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_wb_en(n_out_wb_en), .out_mem_read(n_out_mem_read),
    .out_alu_result(n_out_alu), .out_mem_result(n_out_mem), .out_dest(n_out_dest),
    .occupancy(n_occ)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic valid, input logic wb, input logic mr,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                         input logic [DEST_W-1:0] dest);
    s_in_valid    = valid;
    s_in_wb_en    = wb;
    s_in_mem_read = mr;
    s_in_alu      = alu;
    s_in_mem      = mem;
    s_in_dest     = dest;
  endtask

  initial begin
    // Reset state, sampled while rst is held
    #2;
    check("rst_out_valid", s_out_valid, 0);
    check("rst_occ", s_occ, 0);
    check("rst_in_ready_skid", s_in_ready, 1);
    check("rst_out_alu", s_out_alu, 0);
    check("rst_out_wb_en", s_out_wb_en, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready_noskid", n_in_ready, 1);

    // 1: single transfer, one-cycle latency
    s_out_ready = 1;
    drive_s(1, 1, 0, 32'h0000_00AA, 32'h0000_1234, 4'd3);
    tick();
    drive_s(0, 0, 0, '0, '0, '0);
    #1;
    check("t1_out_valid", s_out_valid, 1);
    check("t1_out_alu", s_out_alu, 32'hAA);
    check("t1_out_mem", s_out_mem, 32'h1234);
    check("t1_out_dest", s_out_dest, 3);
    check("t1_out_wb_en", s_out_wb_en, 1);
    check("t1_out_mem_read", s_out_mem_read, 0);
    check("t1_occ", s_occ, 1);
    tick();
    check("t1_drain_valid", s_out_valid, 0);
    check("t1_drain_wb_en", s_out_wb_en, 0);
    check("t1_hold_alu", s_out_alu, 32'hAA);

    // 2: skid fill with downstream stalled, then ordered drain
    s_out_ready = 0;
    drive_s(1, 1, 1, 32'h11, 32'hDEAD_BEEF, 4'd1);
    tick();
    drive_s(1, 0, 0, 32'h22, 32'h0, 4'd2);
    tick();
    drive_s(0, 0, 0, '0, '0, '0);
    #1;
    check("t2_occ_full", s_occ, 2);
    check("t2_in_ready_low", s_in_ready, 0);
    check("t2_head_A", s_out_alu, 32'h11);
    check("t2_head_A_mem_read", s_out_mem_read, 1);
    check("t2_head_A_mem", s_out_mem, 32'hDEAD_BEEF);
    s_out_ready = 1;
    #1;
    check("t2_in_ready_registered", s_in_ready, 0);
    tick();
    check("t2_head_B", s_out_alu, 32'h22);
    check("t2_head_B_dest", s_out_dest, 2);
    check("t2_head_B_wb_en", s_out_wb_en, 0);
    check("t2_occ_one", s_occ, 1);
    check("t2_in_ready_back", s_in_ready, 1);
    tick();
    check("t2_occ_empty", s_occ, 0);

    // 3: streaming 1..8 with no gaps
    s_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      drive_s(1, 1, 0, DATA_W'(i), '0, DEST_W'(i));
      tick();
      check($sformatf("t3_valid_%0d", i), s_out_valid, 1);
      check($sformatf("t3_alu_%0d", i), s_out_alu, i);
      check($sformatf("t3_occ_%0d", i), s_occ, 1);
    end
    drive_s(0, 0, 0, '0, '0, '0);
    tick();
    check("t3_drained", s_occ, 0);

    // 4: flush with a coincident in_fire
    s_out_ready = 0;
    drive_s(1, 1, 0, 32'h77, '0, 4'd7);
    tick();
    check("t4_full_wb_en", s_out_wb_en, 1);
    drive_s(1, 1, 0, 32'h55, '0, 4'd5);
    s_flush = 1;
    tick();
    s_flush = 0;
    drive_s(0, 0, 0, '0, '0, '0);
    #1;
    check("t4_out_valid", s_out_valid, 0);
    check("t4_out_wb_en", s_out_wb_en, 0);
    check("t4_occ", s_occ, 0);
    check("t4_no_55", s_out_alu, 32'h77);
    tick();
    check("t4_still_empty", s_out_valid, 0);
    check("t4_still_no_55", s_out_alu, 32'h77);

    // 5: SKID=0 combinational ready
    n_out_ready = 0;
    n_in_valid  = 1;
    n_in_alu    = 32'h5A;
    n_in_wb_en  = 1;
    #1;
    check("t5_ready_empty", n_in_ready, 1);
    tick();
    n_in_alu = 32'h5B;
    #1;
    check("t5_ready_stalled", n_in_ready, 0);
    check("t5_occ_full", n_occ, 1);
    tick();
    check("t5_head_held", n_out_alu, 32'h5A);
    check("t5_occ_never_2", n_occ, 1);
    n_out_ready = 1;
    #1;
    check("t5_ready_same_cycle", n_in_ready, 1);
    tick();
    n_in_valid = 0;
    #1;
    check("t5_head_next", n_out_alu, 32'h5B);
    check("t5_occ_stream", n_occ, 1);
    tick();
    check("t5_drained", n_occ, 0);

    // 6: asynchronous reset while SKID_FULL
    s_out_ready = 0;
    drive_s(1, 1, 1, 32'hA1, 32'hB1, 4'd9);
    tick();
    drive_s(1, 1, 0, 32'hA2, 32'hB2, 4'd10);
    tick();
    drive_s(0, 0, 0, '0, '0, '0);
    #1;
    check("t6_skid_full", s_occ, 2);
    #2;
    rst = 1;
    #1;
    check("t6_out_valid", s_out_valid, 0);
    check("t6_out_alu", s_out_alu, 0);
    check("t6_out_mem", s_out_mem, 0);
    check("t6_out_dest", s_out_dest, 0);
    check("t6_out_wb_en", s_out_wb_en, 0);
    check("t6_occ", s_occ, 0);
    check("t6_in_ready", s_in_ready, 1);
    tick();
    rst = 0;
    s_out_ready = 1;
    tick();
    check("t6_after_rst_empty", s_out_valid, 0);
    check("t6_after_rst_occ", s_occ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is short, so any stall here is a bench failure.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
